// File: rtl/linear_layer_fifo_pkg.sv
// Shared definitions for the Linear_Layer start/small-data FIFOs:
// occupancy width helper and handshake-fire helper.
package linear_layer_fifo_pkg;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A request is accepted only when enabled and the opposite side has room/data.
  function automatic logic hs_fire(input logic req, input logic ce, input logic ok);
    return req & ce & ok;
  endfunction

endpackage

// File: rtl/linear_layer_start_srl_store.sv
// Shift-register storage: newest entry at index 0, combinational read at addr.
module linear_layer_start_srl_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // Sized to the full address space so every addr value indexes a real entry.
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[0] <= din;
  end

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (we) mem_q[gi] <= mem_q[gi-1];
      end
    end
  endgenerate

  assign dout = mem_q[addr];

endmodule

// File: rtl/linear_layer_start_srl_fifo.sv
// Start-token / small-data FIFO: occupancy, read address and registered
// full/empty flags around an SRL store.
module linear_layer_start_srl_fifo
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  empty_n_q, full_n_q;
  logic                  push, pop;

  assign push = hs_fire(if_write, if_write_ce, full_n_q);
  assign pop  = hs_fire(if_read, if_read_ce, empty_n_q);

  always_comb begin
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
      // 0->1 keeps the address at 0; the new entry lands there.
      if (count_q != '0) rd_addr_d = rd_addr_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
      if (count_q != (ADDR_WIDTH+1)'(1)) rd_addr_d = rd_addr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      rd_addr_q <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      empty_n_q <= (count_d != '0);
      full_n_q  <= (count_d != CAP);
    end
  end

  linear_layer_start_srl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (push),
    .addr (rd_addr_q),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = CAP;

endmodule

// File: tb/tb_linear_layer_start_srl_fifo.sv
// Directed vector bench for linear_layer_start_srl_fifo (DEPTH=4, 4-bit data).
module tb_linear_layer_start_srl_fifo;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_full_n, if_empty_n;
  logic          if_write_ce, if_write, if_read_ce, if_read;
  logic [DW-1:0] if_din, if_dout;
  logic [AW:0]   if_num_data_valid, if_fifo_cap;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  linear_layer_start_srl_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset),
    .if_full_n(if_full_n), .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
    .if_num_data_valid(if_num_data_valid), .if_fifo_cap(if_fifo_cap)
  );

  typedef struct {
    string    name;
    logic     wr, wce, rd, rce;
    logic [3:0] din;
    int       cnt;
    logic     empty_n, full_n;
    logic     chk_dout;
    logic [3:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic wr, input logic wce, input logic [3:0] din,
                     input logic rd, input logic rce, input int cnt, input logic en,
                     input logic fn, input logic cd, input logic [3:0] dout);
    vec_t v;
    v.name = nm; v.wr = wr; v.wce = wce; v.din = din; v.rd = rd; v.rce = rce;
    v.cnt = cnt; v.empty_n = en; v.full_n = fn; v.chk_dout = cd; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input int cnt, input logic en, input logic fn);
    chk({nm, ".count"}, int'(if_num_data_valid), cnt);
    chk({nm, ".empty_n"}, int'(if_empty_n), int'(en));
    chk({nm, ".full_n"}, int'(if_full_n), int'(fn));
  endtask

  // Inputs driven #1 after a rising edge, consumed at the next edge, checked #1 after it.
  task automatic step(input logic wr, input logic wce, input logic [3:0] din,
                      input logic rd, input logic rce);
    if_write = wr; if_write_ce = wce; if_din = din; if_read = rd; if_read_ce = rce;
    @(posedge clk);
    #1;
    if_write = 1'b0; if_read = 1'b0;
  endtask

  initial begin
    // name, wr, wce, din, rd, rce, count, empty_n, full_n, chk_dout, dout
    add("push_A",      1,1,4'hA, 0,0, 1, 1,1, 1,4'hA);
    add("push_B",      1,1,4'hB, 0,0, 2, 1,1, 1,4'hA);
    add("push_C",      1,1,4'hC, 0,0, 3, 1,1, 1,4'hA);
    add("push_D",      1,1,4'hD, 0,0, 4, 1,0, 1,4'hA);
    add("push_E_full", 1,1,4'hE, 0,0, 4, 1,0, 1,4'hA);
    add("pop1",        0,0,4'h0, 1,1, 3, 1,1, 1,4'hB);
    add("pop2",        0,0,4'h0, 1,1, 2, 1,1, 1,4'hC);
    add("pop3",        0,0,4'h0, 1,1, 1, 1,1, 1,4'hD);
    add("pop4",        0,0,4'h0, 1,1, 0, 0,1, 0,4'h0);
    add("pop_empty",   0,0,4'h0, 1,1, 0, 0,1, 0,4'h0);
    add("both_empty",  1,1,4'h1, 1,1, 1, 1,1, 1,4'h1);
    add("push_2",      1,1,4'h2, 0,0, 2, 1,1, 1,4'h1);
    add("both_cnt2",   1,1,4'h3, 1,1, 2, 1,1, 1,4'h2);
    add("pop_to1",     0,0,4'h0, 1,1, 1, 1,1, 1,4'h3);
    add("pop_to0",     0,0,4'h0, 1,1, 0, 0,1, 0,4'h0);
    for (int i = 0; i < 3; i++) add("wce_low", 1,0,4'h9, 0,0, 0, 0,1, 0,4'h0);
    add("push_7",      1,1,4'h7, 0,0, 1, 1,1, 1,4'h7);
    for (int i = 0; i < 3; i++) add("rce_low", 0,0,4'h0, 1,0, 1, 1,1, 1,4'h7);
    add("push_8",      1,1,4'h8, 0,0, 2, 1,1, 1,4'h7);
    add("push_9",      1,1,4'h9, 0,0, 3, 1,1, 1,4'h7);
    add("push_A2",     1,1,4'hA, 0,0, 4, 1,0, 1,4'h7);
    add("both_full",   1,1,4'hF, 1,1, 3, 1,1, 1,4'h8);
    add("pop_to2",     0,0,4'h0, 1,1, 2, 1,1, 1,4'h9);
    add("push_C2",     1,1,4'hC, 0,0, 3, 1,1, 1,4'h9);

    if_write = 0; if_write_ce = 0; if_read = 0; if_read_ce = 0; if_din = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_state("reset", 0, 1'b0, 1'b1);
    chk("reset.fifo_cap", int'(if_fifo_cap), DP);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].wce, vecs[i].din, vecs[i].rd, vecs[i].rce);
      chk_state(vecs[i].name, vecs[i].cnt, vecs[i].empty_n, vecs[i].full_n);
      if (vecs[i].chk_dout) chk({vecs[i].name, ".dout"}, int'(if_dout), int'(vecs[i].dout));
    end

    // Asynchronous reset at count=3, between edges.
    #2 reset = 1'b1;
    #1;
    chk_state("midreset", 0, 1'b0, 1'b1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
    chk_state("post_reset_push5", 1, 1'b1, 1'b1);
    chk("post_reset_push5.dout", int'(if_dout), 5);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk_state("post_reset_pop", 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/linear_layer_start_srl_fifo.md
# linear_layer_start_srl_fifo

Write/read control wrapper around the shift-register storage used for the start-token and small-data channels between Linear_Layer_i4xi4_q dataflow processes. It owns the occupancy counter, read address, and full/empty handshakes. A producer pushes with the HLS FIFO write handshake and a consumer pops with the read handshake. Data sits in an SRL-style array and is read out at the oldest-entry address.

## Interface
- DATA_WIDTH, 1, payload width (start tokens use 1).
- ADDR_WIDTH, 1, read-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 2, capacity in entries; legal range 2..2**ADDR_WIDTH.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_full_n  out  1  high when at least one entry is free.
- if_write_ce  in  1  write clock enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_empty_n  out  1  high when at least one entry is held.
- if_read_ce  in  1  read clock enable.
- if_read  in  1  read request.
- if_dout  out  DATA_WIDTH  oldest entry; combinational from storage at the current read address.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

## Operation
- push = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n.
- On push, storage shifts by one: entry i moves to i+1, and if_din is written to entry 0. The newest entry is always at index 0. The oldest is at index count-1.
- Read address rd_addr is a register:
  - 0 when count = 0.
  - Otherwise count-1.
  - It is updated together with count so that if_dout = storage[rd_addr] presents the oldest entry with no bubble.
- Occupancy updates:
  - push only: count+1, rd_addr+1, except on the 0→1 transition, where rd_addr stays 0.
  - pop only: count-1, rd_addr-1, except on the 1→0 transition, where rd_addr stays 0.
  - push and pop in the same cycle: count and rd_addr unchanged. The shift moves the next-oldest entry into rd_addr.
  - neither: hold.
- Flags are registered and derived from next-state count:
  - if_empty_n = (count_next != 0).
  - if_full_n = (count_next != DEPTH).
- Boundary conditions:
  - Write while full: ignored. No shift, no count change.
  - Read while empty: ignored. There is no write-to-read bypass, so a push into an empty FIFO is not readable in the same cycle.
  - Full with both requests: only the pop occurs. if_full_n rises the next cycle.
  - Empty with both requests: only the push occurs.
  - CE low: the corresponding request is ignored even if if_write/if_read is high.
- Reset (async assert, any time, including mid-transfer):
  - count=0, rd_addr=0, if_empty_n=0, if_full_n=1, if_num_data_valid=0.
  - Storage is not reset. if_dout is undefined while if_empty_n=0.
  - Entries held at reset are discarded.

## Timing
- Write-to-read latency is 1 cycle. After a push at edge N into an empty FIFO, if_empty_n=1 and if_dout is valid after edge N.
- Pop-to-space latency is 1 cycle. if_full_n reasserts after the pop edge.
- Sustained throughput is 1 push and 1 pop per cycle at any occupancy between 1 and DEPTH-1.
- if_dout changes only after a push or pop edge (address or shift). The mux from rd_addr is the only combinational read path.
- Reset deassertion must be synchronized externally. The first accepted push is on the first edge after release.

## Structure
- Shared package linear_layer_fifo_pkg holds:
  - the occupancy/capacity width function clog2(DEPTH+1);
  - the handshake-fire helper definitions.
- One sub-module, linear_layer_start_srl_store: the SRL array with inputs clk, we (=push), addr (=rd_addr), din, and output dout. It has no reset.
- The control logic (count, rd_addr, flags) lives in the top block.

## Test plan
- Reset defaults, DEPTH=4, ADDR_WIDTH=2: assert reset mid-cycle -> immediately if_empty_n=0, if_full_n=1, if_num_data_valid=0, if_fifo_cap=4.
- Fill and overflow: push 0xA,0xB,0xC,0xD (DATA_WIDTH=4), then push 0xE -> if_full_n=0 after the 4th edge; 0xE dropped; count stays 4; if_dout=0xA.
- Drain order: pop 4 times -> if_dout sequence A,B,C,D; if_empty_n=0 after the 4th pop; a 5th pop leaves count=0.
- Simultaneous push and pop:
  - at count=2 holding {1,2}, push 3 and pop -> count stays 2, next if_dout=2;
  - at full, both requests -> only the pop, count 4→3;
  - at empty, both requests -> only the push, count 0→1.
- CE gating: if_write=1 with if_write_ce=0 for 3 cycles -> count unchanged; the same holds for if_read=1 with if_read_ce=0.
- Reset mid-operation: at count=3, assert reset -> flags return to the empty state asynchronously; after release, push 0x5 -> if_dout=0x5 with count=1.
